// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: bundles the processor-side request/response signals, the
// memory-side req/ack port and the performance counters of cache_ctrl.
//   slave  modport : used by cache_ctrl
//   master modport : used by the processor/memory side (or a testbench)
// Processor side : valid, rw, address_cache, data_wr, flush -> hit, gnt, data_rd
// Memory side    : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack
// Counters       : hit_count, miss_count
interface cache_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              valid;
  logic              rw;
  logic [ADDR_W-1:0] address_cache;
  logic [DATA_W-1:0] data_wr;
  logic              flush;
  logic              hit;
  logic              gnt;
  logic [DATA_W-1:0] data_rd;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [15:0]       hit_count;
  logic [15:0]       miss_count;

  modport slave (
    input  valid, rw, address_cache, data_wr, flush, mem_rdata, mem_ack,
    output hit, gnt, data_rd, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );

  modport master (
    output valid, rw, address_cache, data_wr, flush, mem_rdata, mem_ack,
    input  hit, gnt, data_rd, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller, one DATA_W-wide word per line.
// Ports:
//   clk  - single clock, all state changes on posedge
//   rst  - asynchronous active-low reset
//   bus  - cache_ctrl_if.slave: processor request/response, memory req/ack
//          port and 16-bit saturating hit/miss counters
//
// state  | meaning
// IDLE   | waiting for a request; flush handled here
// LOOKUP | tag compare, counters updated, store-hit line update
// FILL   | load miss: memory read until mem_ack, then line refill
// WRITE  | store (hit or miss): memory write until mem_ack
// RESP   | one-cycle gnt with hit flag and load data
module cache_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int INDEX_W = 4,
  parameter int DATA_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  cache_ctrl_if.slave     bus
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_q;
  logic              hit_q;
  logic [15:0]       hit_cnt_q;
  logic [15:0]       miss_cnt_q;
  logic [LINES-1:0]  line_valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               lookup_hit;

  assign index      = addr_q[INDEX_W-1:0];
  assign tag        = addr_q[ADDR_W-1:INDEX_W];
  assign lookup_hit = line_valid[index] && (tag_arr[index] == tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      line_valid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            line_valid <= '0;
          end else if (bus.valid) begin
            rw_q    <= bus.rw;
            addr_q  <= bus.address_cache;
            wdata_q <= bus.data_wr;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          hit_q <= lookup_hit;
          if (lookup_hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
          end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
          end
          if (!rw_q) begin
            state <= S_WRITE;
          end else if (lookup_hit) begin
            data_q <= data_arr[index];
            state  <= S_RESP;
          end else begin
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            line_valid[index] <= 1'b1;
            data_q            <= bus.mem_rdata;
            state             <= S_RESP;
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; line_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && !rw_q && lookup_hit) begin
      data_arr[index] <= wdata_q;
    end else if (state == S_FILL && bus.mem_ack) begin
      data_arr[index] <= bus.mem_rdata;
      tag_arr[index]  <= tag;
    end
  end

  // Outputs decode from state/registers only, so reset drops mem_req at once.
  assign bus.gnt        = (state == S_RESP);
  assign bus.hit        = (state == S_RESP) && hit_q;
  assign bus.data_rd    = data_q;
  assign bus.mem_req    = (state == S_FILL) || (state == S_WRITE);
  assign bus.mem_we     = (state == S_WRITE);
  assign bus.mem_addr   = ((state == S_FILL) || (state == S_WRITE)) ? addr_q : '0;
  assign bus.mem_wdata  = (state == S_WRITE) ? wdata_q : '0;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed vectors for cache_ctrl with hand-computed results.
module tb_cache_ctrl;
  logic clk;
  logic rst;

  cache_ctrl_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  cache_ctrl #(.ADDR_W(12), .INDEX_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int         g_cyc;
  logic       g_hit;
  logic [7:0] g_rd;
  logic       req_seen;
  logic       we_seen;
  logic [11:0] a_seen;
  logic [7:0] wd_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE, answers mem_req after lat cycles, and
  // records when gnt arrives (cycle 0 = cycle valid is sampled).
  task automatic run_req(input logic is_load, input logic [11:0] a,
                         input logic [7:0] wd, input int lat, input logic [7:0] rdat);
    int rq;
    rq       = 0;
    g_cyc    = -1;
    g_hit    = 1'bx;
    g_rd     = 8'hxx;
    req_seen = 1'b0;
    we_seen  = 1'b0;
    a_seen   = '0;
    wd_seen  = '0;
    @(negedge clk);
    bus.valid         = 1'b1;
    bus.rw            = is_load;
    bus.address_cache = a;
    bus.data_wr       = wd;
    bus.mem_rdata     = rdat;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          we_seen  = bus.mem_we;
          a_seen   = bus.mem_addr;
          wd_seen  = bus.mem_wdata;
        end
        if (rq == lat) bus.mem_ack = 1'b1;
        rq++;
      end
      if (bus.gnt) begin
        g_cyc     = n;
        g_hit     = bus.hit;
        g_rd      = bus.data_rd;
        bus.valid = 1'b0;
        break;
      end
    end
    bus.valid   = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b0;
    bus.valid         = 1'b0;
    bus.rw            = 1'b0;
    bus.address_cache = '0;
    bus.data_wr       = '0;
    bus.flush         = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_ack       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt",      {31'd0, bus.gnt},     32'd0);
    chk("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", {20'd0, bus.mem_addr}, 32'd0);
    chk("rst_data_rd",  {24'd0, bus.data_rd}, 32'd0);
    chk("rst_hit_cnt",  {16'd0, bus.hit_count},  32'd0);
    chk("rst_miss_cnt", {16'd0, bus.miss_count}, 32'd0);
    rst = 1'b1;

    // Load miss, ack two cycles after req.
    run_req(1'b1, 12'h0A5, 8'h00, 2, 8'h3C);
    chk("ld1_cyc",  g_cyc, 32'd5);
    chk("ld1_hit",  {31'd0, g_hit}, 32'd0);
    chk("ld1_rd",   {24'd0, g_rd}, 32'h3C);
    chk("ld1_req",  {31'd0, req_seen}, 32'd1);
    chk("ld1_we",   {31'd0, we_seen}, 32'd0);
    chk("ld1_addr", {20'd0, a_seen}, 32'h0A5);
    chk("ld1_miss", {16'd0, bus.miss_count}, 32'd1);

    // Load hit.
    run_req(1'b1, 12'h0A5, 8'h00, 0, 8'hEE);
    chk("ld2_cyc", g_cyc, 32'd2);
    chk("ld2_hit", {31'd0, g_hit}, 32'd1);
    chk("ld2_rd",  {24'd0, g_rd}, 32'h3C);
    chk("ld2_req", {31'd0, req_seen}, 32'd0);
    chk("ld2_hcnt", {16'd0, bus.hit_count}, 32'd1);

    // Store hit, write-through; data_rd keeps the last load value.
    run_req(1'b0, 12'h0A5, 8'h77, 0, 8'h00);
    chk("st1_cyc",   g_cyc, 32'd3);
    chk("st1_hit",   {31'd0, g_hit}, 32'd1);
    chk("st1_we",    {31'd0, we_seen}, 32'd1);
    chk("st1_addr",  {20'd0, a_seen}, 32'h0A5);
    chk("st1_wdata", {24'd0, wd_seen}, 32'h77);
    chk("st1_rdhold", {24'd0, g_rd}, 32'h3C);
    chk("st1_hcnt",  {16'd0, bus.hit_count}, 32'd2);

    run_req(1'b1, 12'h0A5, 8'h00, 0, 8'hEE);
    chk("ld3_hit", {31'd0, g_hit}, 32'd1);
    chk("ld3_rd",  {24'd0, g_rd}, 32'h77);
    chk("ld3_req", {31'd0, req_seen}, 32'd0);

    // Same index, different tag: replaces the line.
    run_req(1'b1, 12'h1A5, 8'h00, 1, 8'h11);
    chk("ld4_cyc",  g_cyc, 32'd4);
    chk("ld4_hit",  {31'd0, g_hit}, 32'd0);
    chk("ld4_rd",   {24'd0, g_rd}, 32'h11);
    chk("ld4_addr", {20'd0, a_seen}, 32'h1A5);

    run_req(1'b1, 12'h0A5, 8'h00, 0, 8'h77);
    chk("ld5_cyc", g_cyc, 32'd3);
    chk("ld5_hit", {31'd0, g_hit}, 32'd0);
    chk("ld5_rd",  {24'd0, g_rd}, 32'h77);
    chk("ld5_miss", {16'd0, bus.miss_count}, 32'd3);

    // Store miss does not allocate.
    run_req(1'b0, 12'h300, 8'h5A, 1, 8'h00);
    chk("st2_cyc", g_cyc, 32'd4);
    chk("st2_hit", {31'd0, g_hit}, 32'd0);
    chk("st2_we",  {31'd0, we_seen}, 32'd1);
    chk("st2_wdata", {24'd0, wd_seen}, 32'h5A);

    run_req(1'b1, 12'h300, 8'h00, 0, 8'h5A);
    chk("ld6_hit", {31'd0, g_hit}, 32'd0);
    chk("ld6_req", {31'd0, req_seen}, 32'd1);
    chk("ld6_rd",  {24'd0, g_rd}, 32'h5A);

    run_req(1'b1, 12'h300, 8'h00, 0, 8'hEE);
    chk("ld7_hit", {31'd0, g_hit}, 32'd1);
    chk("ld7_counts", {bus.hit_count, bus.miss_count}, {16'd4, 16'd5});

    // Flush in IDLE invalidates everything.
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    run_req(1'b1, 12'h0A5, 8'h00, 0, 8'h77);
    chk("fl_hit", {31'd0, g_hit}, 32'd0);
    chk("fl_req", {31'd0, req_seen}, 32'd1);
    chk("fl_miss", {16'd0, bus.miss_count}, 32'd6);

    // Asynchronous reset in the middle of a fill.
    @(negedge clk);
    bus.valid         = 1'b1;
    bus.rw            = 1'b1;
    bus.address_cache = 12'h0B6;
    @(negedge clk);
    @(negedge clk);
    chk("rf_req_before", {31'd0, bus.mem_req}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rf_req_after",  {31'd0, bus.mem_req}, 32'd0);
    chk("rf_addr_after", {20'd0, bus.mem_addr}, 32'd0);
    chk("rf_counts", {bus.hit_count, bus.miss_count}, 32'd0);
    bus.valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_req(1'b1, 12'h0A5, 8'h00, 0, 8'h77);
    chk("pr_cyc",  g_cyc, 32'd3);
    chk("pr_hit",  {31'd0, g_hit}, 32'd0);
    chk("pr_miss", {16'd0, bus.miss_count}, 32'd1);

    // Saturation of hit_count.
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    chk("sat_pre", {16'd0, bus.hit_count}, 32'hFFFF);
    run_req(1'b1, 12'h0A5, 8'h00, 0, 8'hEE);
    chk("sat_cyc", g_cyc, 32'd2);
    chk("sat_hit", {31'd0, g_hit}, 32'd1);
    chk("sat_cnt", {bus.hit_count, bus.miss_count}, {16'hFFFF, 16'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
